// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer blocks: Gray conversion and
// synchroniser depth bounds used by both the read- and write-side logic.
package fifo_pkg;

   // Allowed depth of the pointer synchroniser chain
   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;

   // Working width of the conversion helpers. Callers zero-extend into this
   // width and cast the result back down; zero upper bits leave both
   // conversions unchanged, so one function serves any pointer width.
   localparam int GRAY_MAX_W = 32;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
      logic [GRAY_MAX_W-1:0] bin;
      bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/sync_w2r.sv
// Plain flop-chain synchroniser bringing the write Gray pointer into rclk.
// Only Gray-coded (single-bit-change) buses may pass through it.
module sync_w2r
   import fifo_pkg::*;
#(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync_r [STAGES];

   // Shift the async input through STAGES flops; cleared by reset
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_r[i] <= '0;
         end
      end else begin
         sync_r[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
      end
   end

   assign q = sync_r[STAGES-1];

endmodule

// File: rtl/rptr_empty_prog.sv
// Read-side pointer and flag generator for the async FIFO.
// Keeps the binary/Gray read pointer with a wrap bit, synchronises the write
// pointer, and registers empty, almost-empty, fill level and sticky underflow.
module rptr_empty_prog
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                rclk,
   input  logic                rrst_n,
   input  logic                rinc,
   input  logic [ADDRSIZE:0]   wptr_gray,
   input  logic [ADDRSIZE:0]   aempty_thresh,
   input  logic                clr_err,
   output logic [ADDRSIZE-1:0] raddr,
   output logic [ADDRSIZE:0]   rptr,
   output logic                rempty,
   output logic                raempty,
   output logic [ADDRSIZE:0]   rlevel,
   output logic                rerr_underflow
);

   localparam int PW = ADDRSIZE + 1;

   if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("rptr_empty_prog: SYNC_STAGES out of range");
   end

   logic [PW-1:0] rbin;
   logic [PW-1:0] rbnext;
   logic [PW-1:0] rgnext;
   logic [PW-1:0] rq_wptr;
   logic [PW-1:0] wbin_s;
   logic [PW-1:0] level_next;
   logic          rd_ok;

   sync_w2r #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_sync_w2r (
      .rclk   (rclk),
      .rrst_n (rrst_n),
      .d      (wptr_gray),
      .q      (rq_wptr)
   );

   // A read is honoured only while not empty; rempty is registered, so there
   // is no combinational path from rinc to the flags.
   assign rd_ok      = rinc & ~rempty;
   assign rbnext     = rbin + PW'(rd_ok);
   assign rgnext     = PW'(bin2gray(GRAY_MAX_W'(rbnext)));
   assign wbin_s     = PW'(gray2bin(GRAY_MAX_W'(rq_wptr)));
   assign level_next = wbin_s - rbnext;

   // Advance the read pointer in binary and Gray form
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rbin <= '0;
         rptr <= '0;
      end else begin
         rbin <= rbnext;
         rptr <= rgnext;
      end
   end

   // Empty, almost-empty and level, all computed against the post-read pointer
   // so a read that consumes the last word flags empty on the same edge
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rempty  <= 1'b1;
         raempty <= 1'b1;
         rlevel  <= '0;
      end else begin
         rempty  <= (rgnext == rq_wptr);
         raempty <= (level_next <= aempty_thresh);
         rlevel  <= level_next;
      end
   end

   // Sticky underflow; a new underflow wins over a simultaneous clear
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rerr_underflow <= 1'b0;
      end else if (rinc && rempty) begin
         rerr_underflow <= 1'b1;
      end else if (clr_err) begin
         rerr_underflow <= 1'b0;
      end
   end

   assign raddr = rbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_rptr_empty_prog.sv
// Directed bench for rptr_empty_prog (ADDRSIZE=4, SYNC_STAGES=2).
module tb_rptr_empty_prog;

   logic       rclk = 1'b0;
   logic       rrst_n = 1'b0;
   logic       rinc = 1'b1;
   logic       clr_err = 1'b0;
   logic [4:0] wptr_gray = 5'h0F;
   logic [4:0] aempty_thresh = 5'd3;
   logic [3:0] raddr;
   logic [4:0] rptr;
   logic       rempty;
   logic       raempty;
   logic [4:0] rlevel;
   logic       rerr_underflow;

   int n_err = 0;
   int n_chk = 0;

   rptr_empty_prog #(.ADDRSIZE(4), .SYNC_STAGES(2)) dut (
      .rclk           (rclk),
      .rrst_n         (rrst_n),
      .rinc           (rinc),
      .wptr_gray      (wptr_gray),
      .aempty_thresh  (aempty_thresh),
      .clr_err        (clr_err),
      .raddr          (raddr),
      .rptr           (rptr),
      .rempty         (rempty),
      .raempty        (raempty),
      .rlevel         (rlevel),
      .rerr_underflow (rerr_underflow)
   );

   always #5 rclk = ~rclk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] gray5(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_rempty"},  32'(rempty),  32'd1);
      check_eq({tag, "_raempty"}, 32'(raempty), 32'd1);
      check_eq({tag, "_rlevel"},  32'(rlevel),  32'd0);
      check_eq({tag, "_rptr"},    32'(rptr),    32'd0);
      check_eq({tag, "_raddr"},   32'(raddr),   32'd0);
      check_eq({tag, "_err"},     32'(rerr_underflow), 32'd0);
   endtask

   logic [4:0] wbin_m;
   logic [4:0] rbin_m;
   logic [4:0] prev_rptr;
   logic [4:0] hold_rptr;
   int         lvl;

   initial begin
      // 1: reset held with rinc high and a nonzero write pointer
      for (int i = 0; i < 4; i++) begin
         tick();
         check_reset_vals("rst_hold");
      end
      wptr_gray = 5'd0;
      rinc      = 1'b0;
      rrst_n    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("post_rst_rempty", 32'(rempty), 32'd1);
         check_eq("post_rst_rlevel", 32'(rlevel), 32'd0);
      end

      // 2: fill to 5, then drain
      wptr_gray = gray5(5'd5);
      tick();
      check_eq("fill_lat1_rempty", 32'(rempty), 32'd1);
      tick();
      check_eq("fill_lat2_rempty", 32'(rempty), 32'd1);
      tick();
      check_eq("fill_rlevel",  32'(rlevel),  32'd5);
      check_eq("fill_rempty",  32'(rempty),  32'd0);
      check_eq("fill_raempty", 32'(raempty), 32'd0);
      rinc = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check_eq("drain_raddr", 32'(raddr), 32'(i));
         tick();
         lvl = 4 - i;
         check_eq("drain_rlevel",  32'(rlevel),  32'(lvl));
         check_eq("drain_raempty", 32'(raempty), 32'(lvl <= 3));
         check_eq("drain_rempty",  32'(rempty),  32'(lvl == 0));
         check_eq("drain_rptr",    32'(rptr),    32'(gray5(5'(i + 1))));
      end
      rinc = 1'b0;
      check_eq("drain_err", 32'(rerr_underflow), 32'd0);

      // 3: 40 write/read pairs, one word in flight, across the pointer wrap
      wbin_m = 5'd5;
      rbin_m = 5'd5;
      for (int n = 0; n < 40; n++) begin
         wbin_m    = wbin_m + 5'd1;
         wptr_gray = gray5(wbin_m);
         tick();
         check_eq("wrap_lat1_rempty", 32'(rempty), 32'd1);
         check_eq("wrap_lat1_rlevel", 32'(rlevel), 32'd0);
         tick();
         check_eq("wrap_lat2_rempty", 32'(rempty), 32'd1);
         check_eq("wrap_lat2_rlevel", 32'(rlevel), 32'd0);
         tick();
         check_eq("wrap_avail_rempty", 32'(rempty), 32'd0);
         check_eq("wrap_avail_rlevel", 32'(rlevel), 32'd1);
         check_eq("wrap_raddr", 32'(raddr), 32'(rbin_m[3:0]));
         prev_rptr = rptr;
         rinc = 1'b1;
         tick();
         rinc   = 1'b0;
         rbin_m = rbin_m + 5'd1;
         check_eq("wrap_rptr",   32'(rptr), 32'(gray5(rbin_m)));
         check_eq("wrap_1bit",   32'($countones(prev_rptr ^ rptr)), 32'd1);
         check_eq("wrap_rempty", 32'(rempty), 32'd1);
         check_eq("wrap_rlevel", 32'(rlevel), 32'd0);
         if (rbin_m == 5'd0) begin
            check_eq("wrap_to_zero_raddr", 32'(raddr), 32'd0);
         end
      end

      // 4: underflow, set-over-clear, then clear
      hold_rptr = rptr;
      rinc = 1'b1;
      tick();
      rinc = 1'b0;
      check_eq("uf_rptr", 32'(rptr), 32'(hold_rptr));
      check_eq("uf_err",  32'(rerr_underflow), 32'd1);
      rinc    = 1'b1;
      clr_err = 1'b1;
      tick();
      rinc = 1'b0;
      check_eq("uf_setclr_err",  32'(rerr_underflow), 32'd1);
      check_eq("uf_setclr_rptr", 32'(rptr), 32'(hold_rptr));
      tick();
      clr_err = 1'b0;
      check_eq("uf_clr_err", 32'(rerr_underflow), 32'd0);

      // 5: full FIFO and threshold boundaries
      rrst_n    = 1'b0;
      wptr_gray = 5'd0;
      tick();
      rrst_n = 1'b1;
      tick();
      wptr_gray = gray5(5'd16);
      repeat (3) tick();
      check_eq("full_rlevel",  32'(rlevel),  32'd16);
      check_eq("full_rempty",  32'(rempty),  32'd0);
      check_eq("full_raempty", 32'(raempty), 32'd0);
      aempty_thresh = 5'd16;
      tick();
      check_eq("thr16_raempty", 32'(raempty), 32'd1);
      aempty_thresh = 5'd15;
      tick();
      check_eq("thr15_raempty", 32'(raempty), 32'd0);
      aempty_thresh = 5'd0;
      tick();
      check_eq("thr0_raempty", 32'(raempty), 32'd0);
      aempty_thresh = 5'd3;

      // 6: reset in the middle of a drain
      rinc = 1'b1;
      repeat (9) tick();
      rinc = 1'b0;
      check_eq("mid_rlevel",  32'(rlevel),  32'd7);
      check_eq("mid_raddr",   32'(raddr),   32'd9);
      check_eq("mid_raempty", 32'(raempty), 32'd0);
      #2;
      rrst_n    = 1'b0;
      wptr_gray = 5'd0;
      #1;
      check_reset_vals("async_rst");
      tick();
      rrst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("rel_rempty", 32'(rempty), 32'd1);
         check_eq("rel_rlevel", 32'(rlevel), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
